// File: rtl/alu_nbits.sv
// Purpose: N-bit ALU with registered S/C/Z flags. It supports add, sub, and, or, xor, shl, shr and an optional multiply.
// Latency: single-cycle ops update at the accepting edge and assert done on the next cycle.
//          A multiply completes WIDTH edges after it is accepted.
// Backpressure: busy is high while a multiply runs. A start seen while busy is dropped.
//
// Parameter: WIDTH  operand/result width in bits (4..32)
// Ports:     clk, rst (async, active-high)
//            start, A, B, op  -- request; A/B/op are captured on the accepting edge
//            S, C, Z          -- registered result and flags; they hold until the next completion
//            busy, done       -- busy is high while a multiply runs; done pulses for one cycle per completion
// Option:    define ALU_NBITS_MUL_EN to build the shift-add multiplier for opcode 111.
//            Without it, opcode 111 completes in one cycle with S=0, C=0, Z=1.

module alu_nbits #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  // Single-cycle datapath, computed directly from the live inputs.
  // Sampling it at the accepting edge is what captures the operands.
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] res_s;
  logic             res_c;

  always_comb begin
    ext   = '0;
    res_s = '0;
    res_c = 1'b0;
    case (op)
      3'b000: begin
        ext   = {1'b0, A} + {1'b0, B};
        res_s = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
      end
      3'b001: begin
        // The extra MSB of the widened difference is the borrow (A < B).
        ext   = {1'b0, A} - {1'b0, B};
        res_s = ext[WIDTH-1:0];
        res_c = ext[WIDTH];
      end
      3'b010: res_s = A & B;
      3'b011: res_s = A | B;
      3'b100: res_s = A ^ B;
      3'b101: begin
        res_s = {A[WIDTH-2:0], 1'b0};
        res_c = A[WIDTH-1];
      end
      3'b110: begin
        res_s = {1'b0, A[WIDTH-1:1]};
        res_c = A[0];
      end
      default: begin
        // Opcode 111 in the single-cycle path yields zero (used when multiply is not built).
        res_s = '0;
        res_c = 1'b0;
      end
    endcase
  end

`ifdef ALU_NBITS_MUL_EN

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_nxt;

  // Shift-add step. The upper half accumulates the multiplicand when the current multiplier bit (prod[0]) is set.
  // The whole register then shifts right, and the multiplier bits drain out of the low half.
  // After WIDTH steps prod holds A*B.
  always_comb begin
    psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){prod[0]}} & {1'b0, mcand});
    prod_nxt = {psum, prod[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
      S     <= '0;
      C     <= 1'b0;
      Z     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op == 3'b111) begin
              state <= MUL;
              busy  <= 1'b1;
              cnt   <= '0;
              mcand <= A;
              prod  <= {{WIDTH{1'b0}}, B};
            end else begin
              S    <= res_s;
              C    <= res_c;
              Z    <= (res_s == '0);
              done <= 1'b1;
            end
          end
        end
        MUL: begin
          // A start seen in this state is dropped, including on the completing edge.
          prod <= prod_nxt;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            S     <= prod_nxt[WIDTH-1:0];
            C     <= |prod_nxt[2*WIDTH-1:WIDTH];
            Z     <= (prod_nxt[WIDTH-1:0] == '0);
            done  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  // No multi-cycle operations exist in this build.
  assign busy = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      S    <= '0;
      C    <= 1'b0;
      Z    <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        S    <= res_s;
        C    <= res_c;
        Z    <= (res_s == '0);
        done <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_alu_nbits.sv
// Purpose: self-checking bench for alu_nbits (WIDTH=8). It applies directed vectors, then random vectors.
// Latency: expected values come from a plain-arithmetic reference model.
// Backpressure: during a multiply, random starts are driven to confirm they are dropped.

module tb_alu_nbits;

  localparam int W = 8;

`ifdef ALU_NBITS_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [2:0]   op;
  logic [W-1:0] S;
  logic         C;
  logic         Z;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Outputs currently held by the DUT, and the outputs the pending operation should produce.
  logic [W-1:0] exp_s, nx_s;
  logic         exp_c, nx_c, exp_z, nx_z;
  int           pend_op;

  alu_nbits #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .op   (op),
    .S    (S),
    .C    (C),
    .Z    (Z),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the opcode rules written as unsigned integer arithmetic.
  task automatic model(input int unsigned a, input int unsigned b, input int o,
                       output logic [W-1:0] s, output logic c);
    longint unsigned m, r, la, lb;
    m  = (64'd1 << W) - 1;
    la = a;
    lb = b;
    r  = 0;
    c  = 1'b0;
    case (o)
      0: begin r = la + lb; c = (r > m); end
      1: begin r = (la + (m + 1) - lb); c = (la < lb); end
      2: r = la & lb;
      3: r = la | lb;
      4: r = la ^ lb;
      5: begin r = la * 2; c = ((la >> (W - 1)) & 1) != 0; end
      6: begin r = la / 2; c = (la % 2) != 0; end
      default: begin
        if (MUL_EN) begin
          r = la * lb;
          c = (r >> W) != 0;
        end
      end
    endcase
    s = W'(r & m);
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
    A       = a;
    B       = b;
    op      = o;
    start   = 1'b1;
    pend_op = int'(o);
    model(a, b, int'(o), nx_s, nx_c);
    nx_z = (nx_s == '0);
  endtask

  task automatic complete(input string tag);
    @(posedge clk); #1;
    start = 1'b0;
    if (MUL_EN && pend_op == 7) begin
      check({tag, ".busy0"}, busy, 1'b1);
      check({tag, ".done0"}, done, 1'b0);
      for (int k = 1; k <= W; k++) begin
        // Garbage starts and inputs while busy. The last one coincides with the completing edge.
        start = (k == W) ? 1'b1 : 1'($urandom_range(0, 1));
        A     = W'($urandom);
        B     = W'($urandom);
        op    = 3'($urandom);
        @(posedge clk); #1;
        if (k < W) begin
          check({tag, ".busy"}, busy, 1'b1);
          check({tag, ".hold_s"}, S, exp_s);
          check({tag, ".nodone"}, done, 1'b0);
        end
      end
      start = 1'b0;
      check({tag, ".s"}, S, nx_s);
      check({tag, ".c"}, C, nx_c);
      check({tag, ".z"}, Z, nx_z);
      check({tag, ".done"}, done, 1'b1);
      check({tag, ".busy_end"}, busy, 1'b0);
      exp_s = nx_s; exp_c = nx_c; exp_z = nx_z;
      @(posedge clk); #1;
      check({tag, ".done_fall"}, done, 1'b0);
      check({tag, ".ignored_s"}, S, exp_s);
      check({tag, ".ignored_busy"}, busy, 1'b0);
    end else begin
      check({tag, ".s"}, S, nx_s);
      check({tag, ".c"}, C, nx_c);
      check({tag, ".z"}, Z, nx_z);
      check({tag, ".done"}, done, 1'b1);
      check({tag, ".busy"}, busy, 1'b0);
      exp_s = nx_s; exp_c = nx_c; exp_z = nx_z;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    A     = '0;
    B     = '0;
    op    = '0;
    exp_s = '0; exp_c = 1'b0; exp_z = 1'b0;

    // Reset state, checked before any clock edge.
    #3;
    check("rst.s", S, 0);
    check("rst.c", C, 0);
    check("rst.z", Z, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    repeat (2) @(posedge clk);

    // The add is requested on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    launch(8'h95, 8'h27, 3'b000);
    complete("add95_27");
    check("add.s_lit", S, 8'hBC);
    @(posedge clk); #1;
    check("add.done_one", done, 1'b0);
    check("add.s_hold", S, 8'hBC);

    // Back-to-back directed ops on consecutive edges.
    @(negedge clk);
    launch(8'h95, 8'h27, 3'b001); complete("sub95_27");
    check("sub.s_lit", S, 8'h6E);
    launch(8'h0A, 8'hD0, 3'b001); complete("sub0A_D0");
    check("sub.borrow_lit", C, 1'b1);
    launch(8'h0A, 8'hD0, 3'b000); complete("add0A_D0");
    check("add2.s_lit", S, 8'hDA);
    launch(8'h81, 8'h00, 3'b101); complete("shl81");
    check("shl.s_lit", S, 8'h02);
    launch(8'h01, 8'h00, 3'b110); complete("shr01");
    check("shr.z_lit", Z, 1'b1);
    launch(8'hF0, 8'h0F, 3'b010); complete("andF0_0F");
    check("and.z_lit", Z, 1'b1);
    launch(8'h0F, 8'h11, 3'b111); complete("op7_0F_11");
    check("op7.s_lit", S, MUL_EN ? 8'hFF : 8'h00);
    @(negedge clk);
    launch(8'h10, 8'h10, 3'b111); complete("op7_10_10");
    check("op7b.c_lit", C, MUL_EN ? 1'b1 : 1'b0);

    // Random operations, with occasional idle gaps between them.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      launch(W'($urandom), W'($urandom), 3'($urandom));
      complete("rand");
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        check("rand.idle_done", done, 1'b0);
        check("rand.idle_s", S, exp_s);
      end
    end

    // Reset in the middle of an operation: a multiply in the full build, an idle cycle otherwise.
    @(negedge clk);
    launch(8'h0F, 8'h11, 3'b111);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst.s", S, 0);
    check("midrst.c", C, 0);
    check("midrst.z", Z, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    exp_s = '0; exp_c = 1'b0; exp_z = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      @(posedge clk); #1;
      check("postrst.done", done, 0);
      check("postrst.busy", busy, 0);
      check("postrst.s", S, 0);
    end
    @(negedge clk);
    launch(8'h01, 8'h01, 3'b000);
    complete("add01_01");
    check("add01.s_lit", S, 8'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nbits.md
ALU_NBITS -- requirements
Module: alu_nbits

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, operand/result width in bits (legal 4..32).
REQ-002 SHALL provide ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  operation request, sampled on rising clk edge.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  opcode.
- S  output  WIDTH  registered result.
- C  output  1  registered carry/borrow/overflow flag.
- Z  output  1  registered zero flag.
- busy  output  1  high while a multi-cycle operation runs.
- done  output  1  one-cycle pulse when S/C/Z are updated.
REQ-003 SHALL have one clock (clk) and one reset (rst); reset SHALL be asynchronous and active-high.

Function
REQ-004 SHALL implement opcodes: 000 add; 001 sub (A-B); 010 and; 011 or; 100 xor; 101 shift-left A by 1; 110 shift-right A by 1 (logical); 111 multiply (A*B, low WIDTH bits).
REQ-005 SHALL accept start only when busy=0; start while busy=1 SHALL be ignored with no effect on state or outputs.
REQ-006 SHALL capture A, B and op at the accepting edge; later input changes SHALL NOT affect the running operation.
REQ-007 Single-cycle ops (000-110): S/C/Z SHALL update at the accepting edge; done SHALL be high for exactly the following cycle; busy SHALL stay 0.
REQ-008 Flags: add C=carry-out; sub C=borrow (1 iff A<B unsigned); and/or/xor C=0; shl C=A[WIDTH-1]; shr C=A[0]; Z=1 iff S==0 for every op.
REQ-009 Arithmetic SHALL be unsigned modulo 2^WIDTH.
REQ-010 State machine SHALL have states IDLE and MUL; IDLE->MUL on accepted op=111; MUL->IDLE after exactly WIDTH shift-add iterations.
REQ-011 Multiply SHALL assert busy from the accepting edge until the completing edge (WIDTH edges later); S/C/Z and done SHALL update at that completing edge, busy low at the same edge.
REQ-012 Multiply C SHALL be 1 iff any bit of the 2*WIDTH-bit product above bit WIDTH-1 is nonzero.
REQ-013 S, C, Z SHALL hold their last values until the next completing operation; S/C/Z SHALL NOT change during MUL iterations.
REQ-014 start on the same edge that completes a multiply SHALL be ignored (busy still 1 at that edge).
REQ-015 Back-to-back single-cycle ops on consecutive edges SHALL each complete with done high on consecutive cycles.

Reset
REQ-016 rst=1 SHALL immediately force S=0, C=0, Z=0, busy=0, done=0, state IDLE, iteration counter 0, regardless of clk.
REQ-017 rst asserted mid-multiply SHALL abort it; no done pulse SHALL follow the reset release.
REQ-018 First start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-019 Macro ALU_NBITS_MUL_EN SHALL compile in the MUL state, iteration counter, product register and opcode 111 multiply.
REQ-020 Without ALU_NBITS_MUL_EN, opcode 111 SHALL complete as a single-cycle op with S=0, C=0, Z=1, done pulsed, busy never asserted.

Verification (WIDTH=8)
REQ-021 Add: A=95, B=27, op=000, start -> next cycle S=BC, C=0, Z=0, done=1 for one cycle.
REQ-022 Sub: A=95, B=27, op=001 -> S=6E, C=0; then A=0A, B=D0, op=001 -> S=3A, C=1; A=0A, B=D0, op=000 -> S=DA, C=0.
REQ-023 Shift/zero: A=81, op=101 -> S=02, C=1; A=01, op=110 -> S=00, C=1, Z=1; A=F0, B=0F, op=010 -> S=00, Z=1, C=0.
REQ-024 Multiply (macro defined): A=0F, B=11, op=111 -> busy high 8 cycles, start pulses during busy ignored, then S=FF, C=0, Z=0, done one cycle; A=10, B=10 -> S=00, C=1, Z=1.
REQ-025 Reset mid-multiply: start A=0F, B=11, op=111, assert rst after 3 cycles -> S=00, busy=0, done=0 immediately; no done after release; next add 01+01 -> S=02.
REQ-026 Macro undefined: A=0F, B=11, op=111 -> next cycle S=00, C=0, Z=1, done=1, busy stays 0.
